shift_sched: RTL and testbench



---
 rtl/shift_sched.sv | 169 ++++++++++++++++
 tb/tb_shift_sched.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_sched.sv
// shift_sched: round-robin scheduler sharing one small-step barrel shift stage
// between two requesters. The accepted request is shifted by at most STEP bit
// positions per cycle until its amount is used up, and the result is returned
// on a valid/ready response channel tagged with the requester ID.
//
// Optional feature macro: SHIFT_SCHED_ROTATE_EN
//   When defined, adds req0_rot / req1_rot. rot = 1 turns each step into a
//   circular rotate. Cycle timing is identical in both builds.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   reqN_valid/reqN_ready  request handshake for requester N (ready is combinational)
//   reqN_data/amt/dir      operand, shift amount, direction (0 = left, 1 = right)
//   reqN_rot               rotate select (only with SHIFT_SCHED_ROTATE_EN)
//   resp_valid/resp_ready  response handshake
//   resp_data/resp_id      shifted result and owning requester
//   busy                   high whenever the scheduler is not idle
module shift_sched #(
  parameter int W     = 8,
  parameter int AMT_W = 3,
  parameter int STEP  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [W-1:0]     req0_data,
  input  logic [AMT_W-1:0] req0_amt,
  input  logic             req0_dir,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [W-1:0]     req1_data,
  input  logic [AMT_W-1:0] req1_amt,
  input  logic             req1_dir,
`ifdef SHIFT_SCHED_ROTATE_EN
  input  logic             req0_rot,
  input  logic             req1_rot,
`endif
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [W-1:0]     resp_data,
  output logic             resp_id,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [AMT_W-1:0] STEP_A = AMT_W'(STEP);

  state_t           state_q;
  logic [W-1:0]     data_q;
  logic [AMT_W-1:0] rem_q;
  logic             dir_q;
  logic             rot_q;
  logic             id_q;
  logic             rr_q;        // 1: requester 1 wins a tie
  logic             resp_valid_q;
  logic             busy_q;

  logic             grant1;
  logic             hs;
  logic [W-1:0]     data_sel;
  logic [AMT_W-1:0] amt_sel;
  logic             dir_sel;
  logic             rot_sel;
  logic [AMT_W-1:0] step_d;
  logic [AMT_W-1:0] rem_d;
  logic [W-1:0]     data_d;

  // Largest step the shared stage can take from the remaining amount.
  function automatic logic [AMT_W-1:0] step_of(input logic [AMT_W-1:0] rem);
    return (rem > STEP_A) ? STEP_A : rem;
  endfunction

  // One pass through the shared stage: logical shift with zero fill, or a
  // rotate where bits leaving one end re-enter at the other.
  function automatic logic [W-1:0] shift_step(input logic [W-1:0]     d,
                                              input logic [AMT_W-1:0] s,
                                              input logic             dir,
                                              input logic             rot);
    logic [2*W-1:0] t;
    if (dir) begin
      t = {d, d} >> s;
      return rot ? t[W-1:0] : (d >> s);
    end else begin
      t = {d, d} << s;
      return rot ? t[2*W-1:W] : (d << s);
    end
  endfunction

  // Requester 1 wins when it is the only one asking, or on a tie it is favoured.
  assign grant1     = req1_valid && (!req0_valid || rr_q);
  assign req1_ready = (state_q == IDLE) && grant1;
  assign req0_ready = (state_q == IDLE) && req0_valid && !grant1;
  assign hs         = req0_ready || req1_ready;

  assign data_sel = grant1 ? req1_data : req0_data;
  assign amt_sel  = grant1 ? req1_amt  : req0_amt;
  assign dir_sel  = grant1 ? req1_dir  : req0_dir;
`ifdef SHIFT_SCHED_ROTATE_EN
  assign rot_sel  = grant1 ? req1_rot  : req0_rot;
`else
  assign rot_sel  = 1'b0;
`endif

  assign step_d = step_of(rem_q);
  assign rem_d  = rem_q - step_d;
  assign data_d = shift_step(data_q, step_d, dir_q, rot_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      data_q       <= '0;
      rem_q        <= '0;
      dir_q        <= 1'b0;
      rot_q        <= 1'b0;
      id_q         <= 1'b0;
      rr_q         <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            data_q <= data_sel;
            rem_q  <= amt_sel;
            dir_q  <= dir_sel;
            rot_q  <= rot_sel;
            id_q   <= grant1;
            rr_q   <= ~grant1;
            busy_q <= 1'b1;
            if (amt_sel != '0) begin
              state_q <= SHIFT;
            end else begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
            end
          end
        end
        SHIFT: begin
          data_q <= data_d;
          rem_q  <= rem_d;
          if (rem_d == '0) begin
            state_q      <= DONE;
            resp_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = data_q;
  assign resp_id    = id_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_shift_sched.sv
module tb_shift_sched;
  localparam int W     = 8;
  localparam int AMT_W = 3;
  localparam int STEP  = 3;
`ifdef SHIFT_SCHED_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0_valid = 1'b0, req1_valid = 1'b0;
  logic             req0_ready, req1_ready;
  logic [W-1:0]     req0_data = '0, req1_data = '0;
  logic [AMT_W-1:0] req0_amt = '0, req1_amt = '0;
  logic             req0_dir = 1'b0, req1_dir = 1'b0;
  logic             req0_rot = 1'b0, req1_rot = 1'b0;
  logic             resp_valid;
  logic             resp_ready = 1'b1;
  logic [W-1:0]     resp_data;
  logic             resp_id;
  logic             busy;

  int tests = 0;
  int fails = 0;
  int rr_m  = 0;   // model of which requester wins a tie

  always #5 clk = ~clk;

  shift_sched #(.W(W), .AMT_W(AMT_W), .STEP(STEP)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_amt(req0_amt), .req0_dir(req0_dir),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_amt(req1_amt), .req1_dir(req1_dir),
`ifdef SHIFT_SCHED_ROTATE_EN
    .req0_rot(req0_rot), .req1_rot(req1_rot),
`endif
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Whole-amount reference: shift or rotate by the full amount in one go.
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int amt,
                                         input bit dir, input bit rot);
    logic [2*W-1:0] t;
    int k;
    if (rot) begin
      k = amt % W;
      if (dir) begin t = {d, d} >> k; return t[W-1:0]; end
      else     begin t = {d, d} << k; return t[2*W-1:W]; end
    end
    if (amt >= W) return '0;
    return dir ? (d >> amt) : (d << amt);
  endfunction

  function automatic logic ready_of(input int id);
    return (id == 1) ? req1_ready : req0_ready;
  endfunction

  function automatic logic valid_of(input int id);
    return (id == 1) ? req1_valid : req0_valid;
  endfunction

  task automatic drive(input int id, input bit v, input logic [W-1:0] d,
                       input logic [AMT_W-1:0] a, input bit dir, input bit rot);
    if (id == 0) begin
      req0_valid = v; req0_data = d; req0_amt = a; req0_dir = dir; req0_rot = rot;
    end else begin
      req1_valid = v; req1_data = d; req1_amt = a; req1_dir = dir; req1_rot = rot;
    end
  endtask

  task automatic drive_rand(input int id, input bit v);
    drive(id, v, W'($urandom), AMT_W'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Called just after a falling edge. Presents a request for `id`, checks the
  // grant, latency, result and tag, optionally stalls the response.
  task automatic send(input int id, input logic [W-1:0] d, input int amt,
                      input bit dir, input bit rot, input bit keep_other,
                      input int stall, input string tag);
    logic [W-1:0] exp_d;
    int exp_lat, lat, other;
    bit seen, other_v;
    other   = 1 - id;
    other_v = valid_of(other);
    exp_d   = model(d, amt, dir, ROT_EN && rot);
    exp_lat = (amt == 0) ? 1 : (amt + STEP - 1) / STEP + 1;
    drive(id, 1'b1, d, AMT_W'(amt), dir, rot);
    #1;
    chk({tag, "_ready"}, ready_of(id), 32'(!other_v || rr_m == id));
    chk({tag, "_other_ready"}, ready_of(other), 0);
    @(posedge clk);
    rr_m = other;
    seen = 1'b0;
    lat  = 0;
    for (int n = 1; n <= 12 && !seen; n++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        lat  = n;
      end else begin
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_ready_in_shift"}, {req1_ready, req0_ready}, 0);
        drive_rand(id, 1'($urandom));
        if (!keep_other) drive_rand(other, 1'($urandom));
      end
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_data"}, resp_data, exp_d);
    chk({tag, "_id"}, resp_id, id);
    if (stall > 0) begin
      resp_ready = 1'b0;
      drive_rand(id, 1'b1);
      if (!keep_other) drive_rand(other, 1'b1);
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        chk({tag, "_stall_valid"}, resp_valid, 1);
        chk({tag, "_stall_data"}, resp_data, exp_d);
        chk({tag, "_stall_id"}, resp_id, id);
        chk({tag, "_stall_ready"}, {req1_ready, req0_ready}, 0);
      end
      resp_ready = 1'b1;
    end
    #1;
    chk({tag, "_ready_in_done"}, {req1_ready, req0_ready}, 0);
    drive(id, 1'b0, '0, '0, 1'b0, 1'b0);
    if (!keep_other) drive(other, 1'b0, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_valid"}, resp_valid, 0);
  endtask

  initial begin
    logic [W-1:0] ld;
    int la, lw;
    bit ldir, lrot;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Tie straight after reset: requester 0 first, then requester 1
    drive(1, 1'b1, 8'h80, 3'd1, 1'b1, 1'b0);
    send(0, 8'h01, 1, 1'b0, 1'b0, 1'b1, 0, "tie_r0");
    send(1, 8'h80, 1, 1'b1, 1'b0, 1'b0, 0, "tie_r1");

    // Directed shifts
    send(0, 8'hB3, 5, 1'b0, 1'b0, 1'b0, 0, "left5");
    send(1, 8'hFF, 7, 1'b1, 1'b0, 1'b0, 0, "right7");
    send(0, 8'h5A, 0, 1'b0, 1'b0, 1'b0, 5, "amt0_stall");

    // Reset while shifting discards the request
    drive(0, 1'b1, 8'hC3, 3'd7, 1'b0, 1'b0);
    @(posedge clk);
    rr_m = 1;
    @(negedge clk);
    drive(0, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rr_m  = 0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", resp_valid, 0);
    chk("mid_rst_data", resp_data, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("mid_rst_no_resp", resp_valid, 0);
    end
    send(1, 8'h3C, 2, 1'b1, 1'b0, 1'b0, 0, "after_rst");

`ifdef SHIFT_SCHED_ROTATE_EN
    send(0, 8'h81, 1, 1'b0, 1'b1, 1'b0, 0, "rot_on");
    send(0, 8'h81, 1, 1'b0, 1'b0, 1'b0, 0, "rot_off");
    send(1, 8'h96, 7, 1'b1, 1'b1, 1'b0, 1, "rot_r7");
`endif

    // Randomized requests, including ties that exercise the pointer
    for (int i = 0; i < 30; i++) begin
      ld   = W'($urandom);
      la   = int'($urandom_range(0, (1 << AMT_W) - 1));
      ldir = 1'($urandom);
      lrot = 1'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        lw = rr_m;
        drive(1 - lw, 1'b1, ld, AMT_W'(la), ldir, lrot);
        send(lw, W'($urandom), int'($urandom_range(0, 7)), 1'($urandom),
             1'($urandom), 1'b1, int'($urandom_range(0, 2)), "rnd_tie_win");
        send(1 - lw, ld, la, ldir, lrot, 1'b0, 0, "rnd_tie_lose");
      end else begin
        send(int'($urandom_range(0, 1)), ld, la, ldir, lrot, 1'b0,
             int'($urandom_range(0, 2)), "rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
